// File: rtl/serializer_pkg.sv
// ---------------------------------------------------------------------------
// serializer_pkg
// Shared types and helpers for unpacked_array_serializer.
//   state_t   : FSM state encoding (IDLE, SHIFT, and PAR when parity is built)
//   idx_width : width of the bit-index counter for an M-bit word
// Optional feature macro: SERIALIZER_PARITY_EN (adds the PAR state).
// ---------------------------------------------------------------------------
package serializer_pkg;

`ifdef SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

   // Index counter width: just enough to address bits 0..M-1.
   function automatic int idx_width(input int m);
      return $clog2(m);
   endfunction

endpackage

// File: rtl/unpacked_array_serializer.sv
// ---------------------------------------------------------------------------
// unpacked_array_serializer
// Captures an M-bit word into a 1-bit-per-entry unpacked array and shifts it
// out LSB first over a valid/ready serial interface.
// Optional feature macro: SERIALIZER_PARITY_EN -- appends an even-parity bit
// (XOR of the captured word) after the data bits.
//
// Ports
//   clock   : in  1  rising-edge clock
//   rst     : in  1  synchronous active-high reset
//   d       : in  M  parallel word, d[0] sent first
//   load    : in  1  capture request, honoured only while idle
//   q       : out 1  serial data bit
//   q_valid : out 1  q holds a valid bit
//   q_ready : in  1  sink accepts q (transfer when q_valid && q_ready)
//   busy    : out 1  high in every state except IDLE
//   done    : out 1  one-cycle pulse after the final transfer of a word
// ---------------------------------------------------------------------------
module unpacked_array_serializer
   import serializer_pkg::*;
#(
   parameter int M = 4
) (
   input  logic         clock,
   input  logic         rst,
   input  logic [M-1:0] d,
   input  logic         load,
   output logic         q,
   output logic         q_valid,
   input  logic         q_ready,
   output logic         busy,
   output logic         done
);

   localparam int            IW   = idx_width(M);
   localparam logic [IW-1:0] LAST = IW'(M - 1);

   state_t        r_state;
   state_t        w_next;
   logic          r_buf [0:M-1];
   logic [IW-1:0] r_idx;
   logic          r_done;
   logic          w_done_next;

`ifdef SERIALIZER_PARITY_EN
   logic w_parity;

   // Even parity of the captured word; buf is stable for the whole word.
   always_comb begin
      w_parity = 1'b0;
      for (int i = 0; i < M; i++) begin
         w_parity = w_parity ^ r_buf[i];
      end
   end
`endif

   // NOTE: every output of this block gets a default before the case so no
   // path leaves a signal unassigned, which would infer a latch.
   always_comb begin
      w_next      = r_state;
      w_done_next = 1'b0;
      q           = 1'b0;
      q_valid     = 1'b0;
      busy        = 1'b0;
      case (r_state)
         IDLE: begin
            if (load) w_next = SHIFT;
         end
         SHIFT: begin
            q       = r_buf[r_idx];
            q_valid = 1'b1;
            busy    = 1'b1;
            if (q_ready && (r_idx == LAST)) begin
`ifdef SERIALIZER_PARITY_EN
               w_next = PAR;
`else
               w_next      = IDLE;
               w_done_next = 1'b1;
`endif
            end
         end
`ifdef SERIALIZER_PARITY_EN
         PAR: begin
            q       = w_parity;
            q_valid = 1'b1;
            busy    = 1'b1;
            if (q_ready) begin
               w_next      = IDLE;
               w_done_next = 1'b1;
            end
         end
`endif
         default: w_next = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_done  <= 1'b0;
         // NOTE: the word storage is explicitly cleared on reset; a reset
         // aborts the word and must leave no stale bits behind.
         for (int i = 0; i < M; i++) begin
            r_buf[i] <= 1'b0;
         end
      end else begin
         r_state <= w_next;
         r_done  <= w_done_next;
         case (r_state)
            IDLE: begin
               if (load) begin
                  for (int i = 0; i < M; i++) begin
                     r_buf[i] <= d[i];
                  end
                  r_idx <= '0;
               end
            end
            SHIFT: begin
               if (q_ready) begin
                  r_idx <= (r_idx == LAST) ? '0 : r_idx + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign done = r_done;

endmodule
